// File: rtl/gyro_spi_poller.sv
// Autonomous AXI-lite master: each poll period it starts an SPI read, polls busy,
// fetches the received word and streams its low 16 bits out as a gyro sample.
module gyro_spi_poller #(
  parameter int unsigned   AW        = 4,
  parameter int unsigned   DW        = 32,
  parameter logic [AW-1:0] CTRL_ADDR = AW'(4'h0),
  parameter logic [AW-1:0] STAT_ADDR = AW'(4'h4),
  parameter logic [AW-1:0] RXD_ADDR  = AW'(4'h8),
  parameter int unsigned   BUSY_BIT  = 0,
  parameter logic [DW-1:0] CMD_WORD  = DW'(32'h0000_8000),
  parameter int unsigned   POLL_DIV  = 1000,
  parameter int unsigned   MAX_POLLS = 255
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            enable,
  input  logic            err_clr,
  output logic            sample_valid,
  output logic [15:0]     sample_data,
  input  logic            sample_ready,
  output logic            overrun,
  output logic            err,
  output logic            m_awvalid,
  input  logic            m_awready,
  output logic [AW-1:0]   m_awaddr,
  output logic [2:0]      m_awprot,
  output logic            m_wvalid,
  input  logic            m_wready,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_wstrb,
  input  logic            m_bvalid,
  output logic            m_bready,
  input  logic [1:0]      m_bresp,
  output logic            m_arvalid,
  input  logic            m_arready,
  output logic [AW-1:0]   m_araddr,
  output logic [2:0]      m_arprot,
  input  logic            m_rvalid,
  output logic            m_rready,
  input  logic [DW-1:0]   m_rdata,
  input  logic [1:0]      m_rresp
);

  localparam int unsigned CW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int unsigned PW = (MAX_POLLS > 0) ? $clog2(MAX_POLLS + 1) : 1;
  localparam int unsigned SW = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_TICK, S_WR, S_B, S_AR_S, S_R_S, S_AR_D, S_R_D
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic            cnt_run;
  logic            tick_c;
  logic            pending, pending_n;
  logic [PW-1:0]   poll_cnt, poll_cnt_n;
  logic            awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
  logic [AW-1:0]   awaddr_n, araddr_n;
  logic [DW-1:0]   wdata_n;
  logic            sample_valid_n, overrun_n, err_n;
  logic [SW-1:0]   sample_data_n;
  logic            aw_left_c, w_left_c;
  state_t          exit_state_c;
  logic            unused_rdata_c;

  assign m_awprot = 3'b000;
  assign m_arprot = 3'b000;
  assign m_wstrb  = '1;
  assign unused_rdata_c = ^m_rdata;

  // Poll-period divider: loads on enable, ticks for one cycle at zero and reloads.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt     <= '0;
      cnt_run <= 1'b0;
    end else if (!enable) begin
      cnt     <= '0;
      cnt_run <= 1'b0;
    end else if (!cnt_run || cnt == '0) begin
      cnt     <= CW'(POLL_DIV - 1);
      cnt_run <= 1'b1;
    end else begin
      cnt     <= cnt - CW'(1);
    end
  end

  assign tick_c = enable && cnt_run && (cnt == '0);

  // State and all registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      pending      <= 1'b0;
      poll_cnt     <= '0;
      m_awvalid    <= 1'b0;
      m_awaddr     <= '0;
      m_wvalid     <= 1'b0;
      m_wdata      <= '0;
      m_bready     <= 1'b0;
      m_arvalid    <= 1'b0;
      m_araddr     <= '0;
      m_rready     <= 1'b0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
      overrun      <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_n;
      pending      <= pending_n;
      poll_cnt     <= poll_cnt_n;
      m_awvalid    <= awvalid_n;
      m_awaddr     <= awaddr_n;
      m_wvalid     <= wvalid_n;
      m_wdata      <= wdata_n;
      m_bready     <= bready_n;
      m_arvalid    <= arvalid_n;
      m_araddr     <= araddr_n;
      m_rready     <= rready_n;
      sample_valid <= sample_valid_n;
      sample_data  <= sample_data_n;
      overrun      <= overrun_n;
      err          <= err_n;
    end
  end

  // Sequencer: write command, poll status, read data, then back to waiting.
  always_comb begin
    state_n        = state;
    pending_n      = pending;
    poll_cnt_n     = poll_cnt;
    awvalid_n      = m_awvalid;
    awaddr_n       = m_awaddr;
    wvalid_n       = m_wvalid;
    wdata_n        = m_wdata;
    bready_n       = m_bready;
    arvalid_n      = m_arvalid;
    araddr_n       = m_araddr;
    rready_n       = m_rready;
    sample_valid_n = sample_valid && !sample_ready;
    sample_data_n  = sample_data;
    overrun_n      = 1'b0;
    err_n          = err && !err_clr;
    aw_left_c      = m_awvalid && !m_awready;
    w_left_c       = m_wvalid && !m_wready;
    exit_state_c   = enable ? S_WAIT_TICK : S_IDLE;

    if (!enable) begin
      pending_n = 1'b0;
    end else if (tick_c && state != S_WAIT_TICK) begin
      pending_n = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (enable) state_n = S_WAIT_TICK;
      end
      S_WAIT_TICK: begin
        if (!enable) begin
          state_n = S_IDLE;
        end else if (tick_c || pending) begin
          pending_n  = 1'b0;
          poll_cnt_n = '0;
          awvalid_n  = 1'b1;
          awaddr_n   = CTRL_ADDR;
          wvalid_n   = 1'b1;
          wdata_n    = CMD_WORD;
          state_n    = S_WR;
        end
      end
      S_WR: begin
        // Each channel drops its valid independently after its own handshake.
        awvalid_n = aw_left_c;
        wvalid_n  = w_left_c;
        if (!aw_left_c && !w_left_c) begin
          bready_n = 1'b1;
          state_n  = S_B;
        end
      end
      S_B: begin
        if (m_bvalid) begin
          bready_n = 1'b0;
          if (m_bresp != 2'b00) begin
            err_n   = 1'b1;
            state_n = exit_state_c;
          end else begin
            arvalid_n = 1'b1;
            araddr_n  = STAT_ADDR;
            state_n   = S_AR_S;
          end
        end
      end
      S_AR_S: begin
        if (m_arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = S_R_S;
        end
      end
      S_R_S: begin
        if (m_rvalid) begin
          rready_n = 1'b0;
          if (m_rresp != 2'b00) begin
            err_n   = 1'b1;
            state_n = exit_state_c;
          end else if (m_rdata[BUSY_BIT]) begin
            if (32'(poll_cnt) < MAX_POLLS) begin
              poll_cnt_n = poll_cnt + PW'(1);
              arvalid_n  = 1'b1;
              araddr_n   = STAT_ADDR;
              state_n    = S_AR_S;
            end else begin
              err_n   = 1'b1;
              state_n = exit_state_c;
            end
          end else begin
            arvalid_n = 1'b1;
            araddr_n  = RXD_ADDR;
            state_n   = S_AR_D;
          end
        end
      end
      S_AR_D: begin
        if (m_arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = S_R_D;
        end
      end
      S_R_D: begin
        if (m_rvalid) begin
          rready_n = 1'b0;
          if (m_rresp == 2'b00) begin
            // Newest sample wins; flag loss only if the old one was not taken now.
            sample_data_n  = m_rdata[SW-1:0];
            sample_valid_n = 1'b1;
            overrun_n      = sample_valid && !sample_ready;
          end else begin
            err_n = 1'b1;
          end
          state_n = exit_state_c;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule
